// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port sequencer for an async 16-bit SRAM; ports Clk/Reset, req/we/addr/wdata/be/ack/rdata x2, busy, SRAM pins A/CE/OE/WE/UB/LB/I_O
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [15:0]       wdata0,
  input  logic [15:0]       wdata1,
  input  logic [1:0]        be0,
  input  logic [1:0]        be1,
  output logic              ack0,
  output logic              ack1,
  output logic [15:0]       rdata0,
  output logic [15:0]       rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] A,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  inout  wire  [15:0]       I_O
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic last_q, last_d, gnt_q, gnt_d, wel_q, wel_d;
  logic [ADDR_W-1:0] addrl_q, addrl_d, a_q, a_d;
  logic [15:0] wdatal_q, wdatal_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0] bel_q, bel_d;
  logic ce_q, ce_d, oe_q, oe_d, we_q, we_d, ub_q, ub_d, lb_q, lb_d;
  logic drv_q, drv_d, ack0_q, ack0_d, ack1_q, ack1_d;
  logic sel, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0] m_wdata;
  logic [1:0] m_be;
  assign sel     = (req0 && req1) ? ~last_q : req1;
  assign m_we    = sel ? we1 : we0;
  assign m_addr  = sel ? addr1 : addr0;
  assign m_wdata = sel ? wdata1 : wdata0;
  assign m_be    = sel ? be1 : be0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    gnt_d = gnt_q;
    wel_d = wel_q;
    addrl_d = addrl_q;
    wdatal_d = wdatal_q;
    bel_d = bel_q;
    a_d = a_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ce_d = 1'b1;
    oe_d = 1'b1;
    we_d = 1'b1;
    ub_d = 1'b1;
    lb_d = 1'b1;
    drv_d = 1'b0;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    case (state_q)
      IDLE: if (req0 || req1) begin
        state_d = SETUP;
        gnt_d = sel;
        last_d = sel;
        wel_d = m_we;
        addrl_d = m_addr;
        wdatal_d = m_wdata;
        bel_d = m_be;
        a_d = m_addr;
        ce_d = 1'b0;
        oe_d = m_we;
        ub_d = ~m_be[1];
        lb_d = ~m_be[0];
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d = 4'(WAIT_CYCLES - 1);
        ce_d = 1'b0;
        oe_d = wel_q;
        we_d = ~wel_q;
        drv_d = wel_q;
        ub_d = ~bel_q[1];
        lb_d = ~bel_q[0];
      end
      ACCESS: begin
        ce_d = 1'b0;
        ub_d = ~bel_q[1];
        lb_d = ~bel_q[0];
        drv_d = wel_q;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          ack0_d = ~gnt_q;
          ack1_d = gnt_q;
          rdata0_d = (!wel_q && !gnt_q) ? I_O : rdata0_q;
          rdata1_d = (!wel_q && gnt_q) ? I_O : rdata1_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
          oe_d = wel_q;
          we_d = ~wel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      gnt_q <= 1'b0;
      wel_q <= 1'b0;
      addrl_q <= '0;
      wdatal_q <= '0;
      bel_q <= '0;
      a_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ce_q <= 1'b1;
      oe_q <= 1'b1;
      we_q <= 1'b1;
      ub_q <= 1'b1;
      lb_q <= 1'b1;
      drv_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      wel_q <= wel_d;
      addrl_q <= addrl_d;
      wdatal_q <= wdatal_d;
      bel_q <= bel_d;
      a_q <= a_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ce_q <= ce_d;
      oe_q <= oe_d;
      we_q <= we_d;
      ub_q <= ub_d;
      lb_q <= lb_d;
      drv_q <= drv_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
    end
  end
  assign busy = state_q != IDLE;
  assign A = a_q;
  assign CE = ce_q;
  assign OE = oe_q;
  assign WE = we_q;
  assign UB = ub_q;
  assign LB = lb_q;
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign I_O = drv_q ? wdatal_q : 16'bz;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with small SRAM models
module tb_sram_arbiter;
  logic Clk = 1'b0, Reset = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [19:0] addr0 = 0, addr1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0;
  logic [1:0] be0 = 0, be1 = 0;
  logic ack0, ack1, busy, ce, oe, we_n, ub, lb;
  logic [15:0] rdata0, rdata1;
  logic [19:0] a;
  wire [15:0] io;
  logic r3 = 0;
  logic ack3_0, ack3_1, busy3, ce3, oe3, we3, ub3, lb3;
  logic [15:0] rd3_0, rd3_1;
  logic [19:0] a3;
  wire [15:0] io3;
  logic tb_drv = 0;
  logic [15:0] mem [16];
  logic [15:0] mem3 [16];
  int checks = 0, errors = 0;
  logic [16:0] m0, m1;
  logic seen;
  always #5 Clk = ~Clk;
  sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20)) dut (
    .Clk(Clk), .Reset(Reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .be0(be0), .be1(be1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .A(a), .CE(ce), .OE(oe), .WE(we_n), .UB(ub), .LB(lb), .I_O(io));
  sram_arbiter #(.WAIT_CYCLES(3), .ADDR_W(20)) dut3 (
    .Clk(Clk), .Reset(Reset), .req0(r3), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(20'd0), .addr1(20'd0), .wdata0(16'h0), .wdata1(16'h0), .be0(2'b11), .be1(2'b11),
    .ack0(ack3_0), .ack1(ack3_1), .rdata0(rd3_0), .rdata1(rd3_1), .busy(busy3),
    .A(a3), .CE(ce3), .OE(oe3), .WE(we3), .UB(ub3), .LB(lb3), .I_O(io3));
  assign io = (!ce && !oe && we_n) ? mem[a[3:0]] : 16'bz;
  assign io = tb_drv ? 16'h5A5A : 16'bz;
  assign io3 = (!ce3 && !oe3 && we3) ? mem3[a3[3:0]] : 16'bz;
  always @(negedge Clk) if (!ce && !we_n) begin
    if (!ub) mem[a[3:0]][15:8] = io[15:8];
    if (!lb) mem[a[3:0]][7:0] = io[7:0];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = 16'h0; mem3[i] = 16'h0; end
    mem[4] = 16'h4444;
    mem3[0] = 16'h1042;
    @(negedge Clk);
    chk("rst_ctl", {ce, oe, we_n, ub, lb}, 5'b11111);
    chk("rst_a", a, 0);
    chk("rst_out", {ack0, ack1, busy, rdata0, rdata1}, 0);
    Reset = 0;
    req0 = 1; we0 = 1; addr0 = 3; wdata0 = 16'hBEEF; be0 = 2'b11;
    @(negedge Clk);
    chk("wr_setup", {ce, oe, we_n, busy, ack0}, 5'b01110);
    chk("wr_addr", a, 3);
    @(negedge Clk);
    chk("wr_access", {ce, oe, we_n}, 3'b010);
    chk("wr_io2", io, 16'hBEEF);
    @(negedge Clk);
    chk("wr_done", {ce, we_n, ack0, ack1}, 4'b0110);
    chk("wr_io3", io, 16'hBEEF);
    req0 = 0;
    @(negedge Clk);
    chk("wr_idle", {ce, ack0, busy}, 3'b100);
    chk("wr_mem", mem[3], 16'hBEEF);
    req1 = 1; we1 = 0; addr1 = 3; be1 = 2'b11;
    @(negedge Clk);
    chk("rd_c1", {ce, oe, we_n}, 3'b001);
    @(negedge Clk);
    chk("rd_c2", {oe, ack1}, 2'b00);
    @(negedge Clk);
    chk("rd_ack", {ack1, ack0, oe}, 3'b101);
    chk("rd_data", rdata1, 16'hBEEF);
    req1 = 0;
    @(negedge Clk);
    req0 = 1; we0 = 1; addr0 = 3; wdata0 = 16'h12AA; be0 = 2'b10;
    @(negedge Clk);
    chk("bw_c1", {ub, lb}, 2'b01);
    @(negedge Clk);
    chk("bw_c2", {we_n, ub, lb}, 3'b001);
    @(negedge Clk);
    chk("bw_c3", {ack0, lb}, 2'b11);
    req0 = 0;
    @(negedge Clk);
    chk("bw_mem", mem[3], 16'h12EF);
    req0 = 1; we0 = 0; be0 = 2'b11;
    repeat (3) @(negedge Clk);
    chk("bw_rd", {ack0, rdata0}, {1'b1, 16'h12EF});
    req0 = 0;
    @(negedge Clk);
    r3 = 1;
    @(negedge Clk);
    chk("w3_c1", {ce3, oe3}, 2'b00);
    repeat (3) @(negedge Clk);
    chk("w3_c4", {oe3, ack3_0}, 2'b00);
    @(negedge Clk);
    chk("w3_ack", {ack3_0, ack3_1, oe3, rd3_0}, {3'b101, 16'h1042});
    r3 = 0;
    Reset = 1;
    req0 = 1; we0 = 0; addr0 = 3; be0 = 2'b11;
    req1 = 1; we1 = 0; addr1 = 4; be1 = 2'b11;
    @(negedge Clk);
    Reset = 0;
    m0 = 0; m1 = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge Clk);
      m0[i] = ack0;
      m1[i] = ack1;
      if (i == 3) req0 = 0;
      if (i == 7) req0 = 1;
      if (i == 11) req0 = 0;
      if (i == 15) req1 = 0;
    end
    chk("ct_ack0", m0, 17'h00808);
    chk("ct_ack1", m1, 17'h08080);
    chk("ct_data", {rdata0, rdata1}, {16'h12EF, 16'h4444});
    req0 = 1; we0 = 1; addr0 = 5; wdata0 = 16'h5555; be0 = 2'b11;
    repeat (2) @(negedge Clk);
    chk("rw_pre", we_n, 0);
    #1 Reset = 1;
    #1;
    chk("rw_ctl", {ce, oe, we_n, busy, ack0}, 5'b11100);
    tb_drv = 1;
    #1;
    chk("rw_io", io, 16'h5A5A);
    tb_drv = 0;
    req0 = 0;
    @(negedge Clk);
    Reset = 0;
    seen = 0;
    repeat (4) begin @(negedge Clk); seen = seen | ack0 | busy; end
    chk("rw_noack", seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
